// File: rtl/exp_golomb_sched.sv
// Bitstream sequencer for the exp-Golomb decoder: buffers bytes MSB-first, issues one
// bit-aligned 16-bit window per ue(v) code and advances by the code length.
module exp_golomb_sched #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       s_data,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    output logic [15:0]      dec_data,
    output logic             dec_valid,
    input  logic             dec_ov,
    input  logic [8:0]       dec_od,
    output logic [8:0]       ue_data,
    output logic             ue_valid,
    output logic             done,
    output logic             err
);

    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, FILL, ISSUE, WAIT, ERR} state_t;

    state_t           state;
    logic [31:0]      bit_buf;
    logic [31:0]      buf_n;
    logic [5:0]       fill;
    logic [5:0]       fill_c;
    logic [5:0]       fill_n;
    logic [3:0]       len_q;
    logic [4:0]       lz;
    logic             found;
    logic             accept;
    logic             consume;
    logic [CNT_W-1:0] rem;
    logic [TMR_W-1:0] timer;

    assign s_ready   = (fill <= 6'd24) && (state != ERR);
    assign cmd_ready = (state == IDLE);
    assign dec_data  = bit_buf[31:16];
    assign dec_valid = (state == ISSUE) && (lz < 5'd8);
    assign accept    = s_valid && s_ready;
    assign consume   = (state == WAIT) && dec_ov;

    // Leading zeros of the window; 16 when the window is all zero.
    always_comb begin
        lz    = 5'd16;
        found = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            if (!found && bit_buf[16+i]) begin
                lz    = 5'(15 - i);
                found = 1'b1;
            end
        end
    end

    // Consume first, then append the new byte right after the surviving bits.
    always_comb begin
        fill_c = consume ? (fill - 6'(len_q)) : fill;
        buf_n  = consume ? (bit_buf << len_q) : bit_buf;
        fill_n = fill_c;
        if (accept) begin
            buf_n  = buf_n | ({s_data, 24'h000000} >> fill_c);
            fill_n = fill_c + 6'd8;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            bit_buf  <= '0;
            fill     <= '0;
            len_q    <= '0;
            rem      <= '0;
            timer    <= '0;
            ue_data  <= '0;
            ue_valid <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            bit_buf  <= buf_n;
            fill     <= fill_n;
            ue_valid <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        rem <= cmd_count;
                        if (cmd_count == '0) done  <= 1'b1;
                        else                 state <= FILL;
                    end
                end
                FILL: begin
                    if (fill >= 6'd16) state <= ISSUE;
                end
                ISSUE: begin
                    if (lz >= 5'd8) begin
                        state <= ERR;
                        err   <= 1'b1;
                    end else begin
                        len_q <= {lz[2:0], 1'b1};
                        timer <= '0;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (dec_ov) begin
                        ue_data  <= dec_od;
                        ue_valid <= 1'b1;
                        rem      <= rem - CNT_W'(1);
                        if (rem == CNT_W'(1)) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end else begin
                            state <= FILL;
                        end
                    end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                        state <= ERR;
                        err   <= 1'b1;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                ERR: begin
                    err <= 1'b1;
                end
                default: begin
                    state <= ERR;
                    err   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exp_golomb_sched.sv
// Directed bench for exp_golomb_sched with a behavioural decoder and an expected-value queue.
module tb_exp_golomb_sched;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] s_data = '0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] cmd_count = '0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [15:0] dec_data;
    logic       dec_valid;
    logic       dec_ov = 1'b0;
    logic [8:0] dec_od = '0;
    logic [8:0] ue_data;
    logic       ue_valid;
    logic       done;
    logic       err;

    int total = 0;
    int bad = 0;
    int ue_cnt = 0;
    int dv_cnt = 0;
    int done_cnt = 0;
    int stall_cnt = 0;
    logic done_with_ue = 1'b0;
    logic dec_en = 1'b1;
    int exp_q[$];

    exp_golomb_sched #(.TIMEOUT(64), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .cmd_count(cmd_count), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .dec_data(dec_data), .dec_valid(dec_valid),
        .dec_ov(dec_ov), .dec_od(dec_od),
        .ue_data(ue_data), .ue_valid(ue_valid), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] eg_decode(input logic [15:0] w);
        int z;
        z = 16;
        for (int i = 15; i >= 0; i--) if (z == 16 && w[i]) z = 15 - i;
        if (z > 7) return 9'h1FF;
        return 9'((w >> (15 - 2 * z)) - 1);
    endfunction

    // Decoder model: result one cycle after the strobe.
    always @(posedge clk) begin
        dec_ov <= dec_valid && dec_en;
        dec_od <= eg_decode(dec_data);
    end

    // Output monitor: pops the scoreboard on every ue_valid.
    always @(posedge clk) begin
        #2;
        if (rst_n) begin
            if (dec_valid) dv_cnt++;
            if (done) begin
                done_cnt++;
                done_with_ue = ue_valid;
            end
            if (ue_valid) begin
                ue_cnt++;
                if (exp_q.size() == 0) check("ue_unexpected", 32'(ue_data), 32'h0DEAD);
                else check("ue_data", 32'(ue_data), 32'(exp_q.pop_front()));
            end
            if (dut.fill > 6'd24) begin
                stall_cnt++;
                check("s_ready_full", 32'(s_ready), 32'h0);
            end
        end
    end

    task automatic push_byte(input logic [7:0] b);
        int n;
        n = 0;
        s_data = b;
        s_valid = 1'b1;
        while (!s_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("push_timeout", 32'(n), 32'h0);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] n);
        cmd_count = n;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_ue(input int target, input int budget);
        int n;
        n = 0;
        while (ue_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("ue_count", 32'(ue_cnt), 32'(target));
    endtask

    task automatic do_reset();
        @(negedge clk);
        s_valid = 1'b0;
        cmd_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        exp_q.delete();
        @(negedge clk);
    endtask

    initial begin
        int base_ue;
        int base_dv;
        int base_done;
        int n;

        // Reset state
        #12;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ue_valid", 32'(ue_valid), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_ue_data", 32'(ue_data), 32'h0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'h1);
        check("rst_s_ready", 32'(s_ready), 32'h1);
        check("rst_dec_valid", 32'(dec_valid), 32'h0);

        // Five codes from A6 48 00 00
        push_byte(8'hA6); push_byte(8'h48); push_byte(8'h00); push_byte(8'h00);
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
        exp_q.push_back(3); exp_q.push_back(0);
        base_dv = dv_cnt; base_done = done_cnt;
        send_cmd(8'd5);
        wait_ue(5, 100);
        check("t1_done_cnt", 32'(done_cnt - base_done), 32'h1);
        check("t1_done_with_ue", 32'(done_with_ue), 32'h1);
        check("t1_dv_cnt", 32'(dv_cnt - base_dv), 32'h5);
        check("t1_fill", 32'(dut.fill), 32'd19);
        check("t1_q_empty", 32'(exp_q.size()), 32'h0);

        // Zero-count command
        base_ue = ue_cnt; base_dv = dv_cnt; base_done = done_cnt;
        cmd_count = 8'd0;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("t2_done_pulse", 32'(done), 32'h1);
        @(negedge clk);
        check("t2_done_low", 32'(done), 32'h0);
        repeat (3) @(negedge clk);
        check("t2_done_cnt", 32'(done_cnt - base_done), 32'h1);
        check("t2_no_dv", 32'(dv_cnt - base_dv), 32'h0);
        check("t2_no_ue", 32'(ue_cnt - base_ue), 32'h0);
        check("t2_cmd_ready", 32'(cmd_ready), 32'h1);

        // Illegal code with eight leading zeros
        do_reset();
        base_dv = dv_cnt;
        push_byte(8'h00); push_byte(8'h80); push_byte(8'hFF);
        send_cmd(8'd1);
        n = 0;
        while (!err && n < 20) begin @(negedge clk); n++; end
        check("t3_err", 32'(err), 32'h1);
        check("t3_no_dv", 32'(dv_cnt - base_dv), 32'h0);
        check("t3_s_ready", 32'(s_ready), 32'h0);
        check("t3_cmd_ready", 32'(cmd_ready), 32'h0);
        cmd_valid = 1'b1; s_valid = 1'b1;
        repeat (5) @(negedge clk);
        cmd_valid = 1'b0; s_valid = 1'b0;
        check("t3_err_sticky", 32'(err), 32'h1);
        check("t3_cmd_ready_hold", 32'(cmd_ready), 32'h0);
        check("t3_no_dv_hold", 32'(dv_cnt - base_dv), 32'h0);
        do_reset();
        check("t3_err_cleared", 32'(err), 32'h0);

        // Decoder timeout
        dec_en = 1'b0;
        base_ue = ue_cnt;
        push_byte(8'h80); push_byte(8'h00);
        send_cmd(8'd1);
        n = 0;
        while (!dec_valid && n < 20) begin @(negedge clk); n++; end
        check("t4_issue_seen", 32'(dec_valid), 32'h1);
        repeat (64) @(negedge clk);
        check("t4_err_before", 32'(err), 32'h0);
        @(negedge clk);
        check("t4_err_at_64", 32'(err), 32'h1);
        check("t4_no_ue", 32'(ue_cnt - base_ue), 32'h0);
        dec_en = 1'b1;
        do_reset();

        // Streaming 3-bit codes with back-pressure
        base_ue = ue_cnt; stall_cnt = 0;
        for (int i = 0; i < 20; i++) exp_q.push_back(1);
        send_cmd(8'd20);
        for (int r = 0; r < 3; r++) begin
            push_byte(8'h49); push_byte(8'h24); push_byte(8'h92);
        end
        push_byte(8'h49);
        wait_ue(base_ue + 20, 300);
        check("t5_q_empty", 32'(exp_q.size()), 32'h0);
        check("t5_stalled", 32'(stall_cnt > 0), 32'h1);
        check("t5_fill", 32'(dut.fill), 32'd20);
        check("t5_last_ue", 32'(ue_data), 32'h1);

        // Asynchronous reset while a code is in flight
        dec_en = 1'b0;
        send_cmd(8'd3);
        n = 0;
        while (!dec_valid && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        check("t6_rem", 32'(dut.rem), 32'd3);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_rst_ue_data", 32'(ue_data), 32'h0);
        check("t6_rst_ue_valid", 32'(ue_valid), 32'h0);
        check("t6_rst_done", 32'(done), 32'h0);
        check("t6_rst_err", 32'(err), 32'h0);
        check("t6_rst_dec_valid", 32'(dec_valid), 32'h0);
        check("t6_rst_cmd_ready", 32'(cmd_ready), 32'h1);
        check("t6_rst_s_ready", 32'(s_ready), 32'h1);
        check("t6_rst_fill", 32'(dut.fill), 32'h0);
        check("t6_rst_dec_data", 32'(dec_data), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        dec_en = 1'b1;
        exp_q.delete();
        @(negedge clk);
        base_ue = ue_cnt;
        push_byte(8'h80); push_byte(8'h00);
        exp_q.push_back(0);
        send_cmd(8'd1);
        wait_ue(base_ue + 1, 50);
        check("t6_q_empty", 32'(exp_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
